// File: rtl/axis_video_pkg.sv
// Shared definitions for the AXI4-Stream video blocks: frame FSM encoding and
// stride normalisation.
package axis_video_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } vid_state_e;

  localparam int STEP_MAX_BITS = 16;

  // A stride of 0 means "every pixel", i.e. the same as 1.
  function automatic logic [STEP_MAX_BITS-1:0] norm_step(input logic [STEP_MAX_BITS-1:0] s);
    return (s == '0) ? {{(STEP_MAX_BITS-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/axis_window_v2_coord.sv
// Pixel coordinate tracking for the window crop: row/col counters, stride
// phases, per-frame window shadow registers and the select/first/last flags.
module axis_window_v2_coord
  import axis_video_pkg::*;
#(
  parameter int C_IMG_WBITS = 12,
  parameter int C_IMG_HBITS = 12,
  parameter int C_STEP_BITS = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   proc_i,
  input  logic                   tuser_i,
  input  logic                   tlast_i,
  input  logic [C_IMG_WBITS-1:0] win_left_i,
  input  logic [C_IMG_HBITS-1:0] win_top_i,
  input  logic [C_IMG_WBITS-1:0] win_width_i,
  input  logic [C_IMG_HBITS-1:0] win_height_i,
  input  logic [C_STEP_BITS-1:0] win_hstep_i,
  input  logic [C_STEP_BITS-1:0] win_vstep_i,
  output logic                   sel_o,
  output logic                   first_o,
  output logic                   last_o
);

  localparam int XW = C_IMG_WBITS + 2;
  localparam int YW = C_IMG_HBITS + 2;

  logic [C_IMG_WBITS-1:0] left_q, width_q, col_q, col_d;
  logic [C_IMG_HBITS-1:0] top_q, height_q, row_q, row_d;
  logic [C_STEP_BITS-1:0] hstep_q, vstep_q, hph_q, hph_d, vph_q, vph_d;
  logic                   ff_q, ff_d;

  logic [C_IMG_WBITS-1:0] left_e, width_e, col_e;
  logic [C_IMG_HBITS-1:0] top_e, height_e, row_e;
  logic [C_STEP_BITS-1:0] hstep_e, vstep_e, hph_e, vph_e;
  logic                   ff_e;
  logic [XW-1:0]          col_x, left_x, h_end;
  logic [YW-1:0]          row_y, top_y, v_end;
  logic                   in_h, in_v;

  // The SOF beat itself already sees the new window and a zeroed position.
  always_comb begin
    left_e   = tuser_i ? win_left_i   : left_q;
    top_e    = tuser_i ? win_top_i    : top_q;
    width_e  = tuser_i ? win_width_i  : width_q;
    height_e = tuser_i ? win_height_i : height_q;
    hstep_e  = tuser_i ? C_STEP_BITS'(norm_step(STEP_MAX_BITS'(win_hstep_i))) : hstep_q;
    vstep_e  = tuser_i ? C_STEP_BITS'(norm_step(STEP_MAX_BITS'(win_vstep_i))) : vstep_q;
    col_e    = tuser_i ? '0 : col_q;
    row_e    = tuser_i ? '0 : row_q;
    hph_e    = tuser_i ? '0 : hph_q;
    vph_e    = tuser_i ? '0 : vph_q;
    ff_e     = tuser_i | ff_q;

    col_x  = XW'(col_e);
    left_x = XW'(left_e);
    h_end  = XW'(left_e) + XW'(width_e);
    row_y  = YW'(row_e);
    top_y  = YW'(top_e);
    v_end  = YW'(top_e) + YW'(height_e);

    in_h    = (col_x >= left_x) && (col_x < h_end);
    in_v    = (row_y >= top_y) && (row_y < v_end);
    sel_o   = in_h && in_v && (hph_e == '0) && (vph_e == '0);
    first_o = sel_o && ff_e;
    last_o  = sel_o && (tlast_i || ((col_x + XW'(hstep_e)) >= h_end));
  end

  always_comb begin
    col_d = col_e;
    row_d = row_e;
    hph_d = hph_e;
    vph_d = vph_e;
    ff_d  = ff_e && !sel_o;
    if (tlast_i) begin
      col_d = '0;
      hph_d = '0;
      row_d = (row_e == '1) ? row_e : row_e + 1'b1;
      if (row_y >= top_y)
        vph_d = (vph_e == vstep_e - 1'b1) ? '0 : vph_e + 1'b1;
      else
        vph_d = '0;
    end else begin
      col_d = (col_e == '1) ? col_e : col_e + 1'b1;
      if (col_x >= left_x)
        hph_d = (hph_e == hstep_e - 1'b1) ? '0 : hph_e + 1'b1;
      else
        hph_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      left_q   <= '0;
      top_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      hstep_q  <= '0;
      vstep_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      hph_q    <= '0;
      vph_q    <= '0;
      ff_q     <= 1'b0;
    end else if (proc_i) begin
      left_q   <= left_e;
      top_q    <= top_e;
      width_q  <= width_e;
      height_q <= height_e;
      hstep_q  <= hstep_e;
      vstep_q  <= vstep_e;
      col_q    <= col_d;
      row_q    <= row_d;
      hph_q    <= hph_d;
      vph_q    <= vph_d;
      ff_q     <= ff_d;
    end
  end

endmodule

// File: rtl/axis_window_v2.sv
// AXI4-Stream video window crop with integer decimation; frame FSM, handshake
// and a single registered output stage.
module axis_window_v2
  import axis_video_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WBITS   = 12,
  parameter int C_IMG_HBITS   = 12,
  parameter int C_STEP_BITS   = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [C_IMG_WBITS-1:0]   win_left,
  input  logic [C_IMG_HBITS-1:0]   win_top,
  input  logic [C_IMG_WBITS-1:0]   win_width,
  input  logic [C_IMG_HBITS-1:0]   win_height,
  input  logic [C_STEP_BITS-1:0]   win_hstep,
  input  logic [C_STEP_BITS-1:0]   win_vstep,
  input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);

  vid_state_e               state_q, state_d;
  logic                     acc, proc, sel, first, last, load;
  logic [C_PIXEL_WIDTH-1:0] data_q, data_d;
  logic                     user_q, user_d, last_q, last_d, vld_q, vld_d;

  assign s_axis_tready = !vld_q || m_axis_tready;
  assign acc           = s_axis_tvalid && s_axis_tready;

  axis_window_v2_coord #(
    .C_IMG_WBITS (C_IMG_WBITS),
    .C_IMG_HBITS (C_IMG_HBITS),
    .C_STEP_BITS (C_STEP_BITS)
  ) u_coord (
    .clk          (clk),
    .resetn       (resetn),
    .proc_i       (proc),
    .tuser_i      (s_axis_tuser),
    .tlast_i      (s_axis_tlast),
    .win_left_i   (win_left),
    .win_top_i    (win_top),
    .win_width_i  (win_width),
    .win_height_i (win_height),
    .win_hstep_i  (win_hstep),
    .win_vstep_i  (win_vstep),
    .sel_o        (sel),
    .first_o      (first),
    .last_o       (last)
  );

  always_comb begin
    state_d = state_q;
    proc    = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        if (acc && s_axis_tuser) begin
          state_d = ACTIVE;
          proc    = 1'b1;
        end
      end
      ACTIVE: proc = acc;
      default: state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= WAIT_SOF;
    else         state_q <= state_d;
  end

  // Output stage: reloads whenever the slot is free, holds while stalled.
  always_comb begin
    load   = proc && sel;
    vld_d  = vld_q;
    data_d = data_q;
    user_d = user_q;
    last_d = last_q;
    if (s_axis_tready) begin
      vld_d = load;
      if (load) begin
        data_d = s_axis_tdata;
        user_d = first;
        last_d = last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      user_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      user_q <= user_d;
      last_q <= last_d;
    end
  end

  assign m_axis_tvalid = vld_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tlast  = last_q;

endmodule

// File: tb/tb_axis_window_v2.sv
// Randomised bench for axis_window_v2 against a coordinate-level crop model.
module tb_axis_window_v2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] win_left = '0, win_width = '0;
  logic [11:0] win_top = '0, win_height = '0;
  logic [3:0]  win_hstep = '0, win_vstep = '0;
  logic [7:0]  s_tdata = '0;
  logic        s_tuser = 1'b0, s_tlast = 1'b0, s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tuser, m_tlast, m_tvalid;
  logic        m_tready = 1'b1;

  always #5 clk = ~clk;

  axis_window_v2 dut (
    .clk           (clk),
    .resetn        (resetn),
    .win_left      (win_left),
    .win_top       (win_top),
    .win_width     (win_width),
    .win_height    (win_height),
    .win_hstep     (win_hstep),
    .win_vstep     (win_vstep),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  typedef struct {
    logic [7:0] d;
    logic       u;
    logic       l;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0, errors = 0;
  int    out_cnt = 0, n_user = 0, n_last = 0;
  logic [7:0] first_d = '0;
  bit    bp_en = 0, gap_en = 0;

  bit m_active = 0, m_first = 0;
  int ml, mt, mw, mh, mhs, mvs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Window crop as seen from the frame: coordinates, window rectangle, strides.
  task automatic model_beat(input int r, input int c, input logic [7:0] d, input bit u, input bit l);
    beat_t b;
    if (u) begin
      m_active = 1;
      m_first  = 1;
      ml  = int'(win_left);
      mt  = int'(win_top);
      mw  = int'(win_width);
      mh  = int'(win_height);
      mhs = (win_hstep == 0) ? 1 : int'(win_hstep);
      mvs = (win_vstep == 0) ? 1 : int'(win_vstep);
    end
    if (!m_active) return;
    if (c >= ml && c < ml + mw && r >= mt && r < mt + mh &&
        ((c - ml) % mhs) == 0 && ((r - mt) % mvs) == 0) begin
      b.d = d;
      b.u = m_first;
      b.l = l || (c + mhs >= ml + mw);
      exp_q.push_back(b);
      m_first = 0;
    end
  endtask

  task automatic drive_beat(input int r, input int c, input bit u, input bit l);
    int  tmo;
    bit  ok;
    logic [7:0] d;
    d = 8'(r * 16 + c);
    if (gap_en) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
    end
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    tmo = 0; ok = 0;
    while (!ok && tmo < 1000) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk); #1;
      tmo++;
    end
    if (!ok) check("accept_timeout", 32'(tmo), 32'd0);
    else     model_beat(r, c, d, u, l);
    s_tvalid = 1'b0;
  endtask

  task automatic send_line(input int w, input int r, input int c0, input int c1, input bit sof);
    for (int c = c0; c < c1; c++)
      drive_beat(r, c, sof && (c == c0), c == w - 1);
  endtask

  task automatic send_rows(input int w, input int r0, input int r1, input bit sof);
    for (int r = r0; r < r1; r++)
      send_line(w, r, 0, w, sof && (r == r0));
  endtask

  task automatic set_win(input int l, input int t, input int w, input int h, input int hs, input int vs);
    win_left = 12'(l); win_top = 12'(t); win_width = 12'(w); win_height = 12'(h);
    win_hstep = 4'(hs); win_vstep = 4'(vs);
  endtask

  task automatic clr_cnt();
    out_cnt = 0; n_user = 0; n_last = 0; first_d = '0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || m_tvalid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      m_tready = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Output monitor: ordering against the model plus hold-under-stall.
  initial begin
    bit        stall;
    logic [10:0] hold_v;
    beat_t     b;
    stall = 0;
    hold_v = '0;
    forever begin
      @(negedge clk);
      if (!resetn) stall = 0;
      else begin
        if (stall) check("stable", {m_tvalid, m_tuser, m_tlast, m_tdata}, {3'b0, hold_v});
        if (m_tvalid && m_tready) begin
          out_cnt++;
          if (m_tuser) begin n_user++; first_d = m_tdata; end
          if (m_tlast) n_last++;
          check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("data", 32'(m_tdata), 32'(b.d));
            check("user", 32'(m_tuser), 32'(b.u));
            check("last", 32'(m_tlast), 32'(b.l));
          end
          stall = 0;
        end else if (m_tvalid) begin
          stall = 1;
          hold_v = {m_tvalid, m_tuser, m_tlast, m_tdata};
        end else stall = 0;
      end
    end
  end

  initial begin
    int w, h;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(m_tvalid), 32'd0);
    check("rst_user", 32'(m_tuser), 32'd0);
    check("rst_last", 32'(m_tlast), 32'd0);
    check("rst_data", 32'(m_tdata), 32'd0);
    check("rst_ready", 32'(s_tready), 32'd1);
    resetn = 1'b1;

    clr_cnt();
    set_win(3, 2, 5, 3, 1, 1);
    send_rows(16, 0, 8, 1);
    drain("basic_drain");
    check("basic_cnt", 32'(out_cnt), 32'd15);
    check("basic_users", 32'(n_user), 32'd1);
    check("basic_lasts", 32'(n_last), 32'd3);
    check("basic_first", 32'(first_d), 32'h23);

    clr_cnt();
    set_win(3, 2, 5, 4, 2, 2);
    send_rows(16, 0, 8, 1);
    drain("dec_drain");
    check("dec_cnt", 32'(out_cnt), 32'd6);
    check("dec_lasts", 32'(n_last), 32'd2);

    clr_cnt();
    set_win(14, 6, 5, 5, 1, 1);
    send_rows(16, 0, 8, 1);
    drain("edge_drain");
    check("edge_cnt", 32'(out_cnt), 32'd4);
    check("edge_lasts", 32'(n_last), 32'd2);
    check("edge_first", 32'(first_d), 32'h6E);

    clr_cnt();
    set_win(3, 3, 0, 6, 1, 1);
    send_rows(16, 0, 5, 1);
    set_win(3, 3, 5, 6, 1, 1);
    send_rows(16, 5, 10, 0);
    drain("empty_drain");
    check("empty_cnt", 32'(out_cnt), 32'd0);
    clr_cnt();
    send_rows(16, 0, 10, 1);
    drain("latch_drain");
    check("latch_cnt", 32'(out_cnt), 32'd30);
    check("latch_first", 32'(first_d), 32'h33);
    check("latch_users", 32'(n_user), 32'd1);

    clr_cnt();
    bp_en = 1; gap_en = 1;
    set_win(3, 2, 5, 3, 1, 1);
    repeat (3) send_rows(16, 0, 8, 1);
    drain("bp_drain");
    check("bp_cnt", 32'(out_cnt), 32'd45);
    check("bp_users", 32'(n_user), 32'd3);
    check("bp_lasts", 32'(n_last), 32'd9);

    bp_en = 0; gap_en = 0;
    @(posedge clk); #1;
    clr_cnt();
    send_rows(16, 0, 4, 1);
    send_line(16, 4, 0, 6, 0);
    s_tdata = 8'h46; s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", 32'(m_tvalid), 32'd0);
    check("midrst_ready", 32'(s_tready), 32'd1);
    s_tvalid = 1'b0;
    resetn = 1'b1;
    exp_q.delete();
    m_active = 0;
    clr_cnt();
    send_rows(16, 5, 8, 0);
    drain("nosof_drain");
    check("nosof_cnt", 32'(out_cnt), 32'd0);
    send_rows(16, 0, 8, 1);
    drain("resume_drain");
    check("resume_cnt", 32'(out_cnt), 32'd15);
    check("resume_first", 32'(first_d), 32'h23);

    bp_en = 1; gap_en = 1;
    for (int f = 0; f < 8; f++) begin
      w = $urandom_range(20, 1);
      h = $urandom_range(10, 1);
      set_win($urandom_range(w, 0), $urandom_range(h, 0), $urandom_range(w, 0),
               $urandom_range(h, 0), $urandom_range(3, 0), $urandom_range(3, 0));
      if ($urandom_range(2, 0) == 0) send_rows(w, 0, (h + 1) / 2, 1);
      send_rows(w, 0, 1, 1);
      set_win($urandom_range(w, 0), $urandom_range(h, 0), $urandom_range(w, 0),
               $urandom_range(h, 0), $urandom_range(3, 0), $urandom_range(3, 0));
      send_rows(w, 1, h, 0);
    end
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_window_v2.md
Name: axis_window_v2

Overview:
- Parametrised successor to the video window crop.
- Crops a rectangular window from an AXI4-Stream video frame, with integer horizontal and vertical decimation (stride).
- Window and stride are latched per frame. The output register stage sustains full throughput under backpressure.
- Sits between the sensor/VDMA stream source and downstream scalers/overlay blocks.

Parameters:
- C_PIXEL_WIDTH, 8: bits per pixel (tdata width).
- C_IMG_WBITS, 12: width of column coordinates and window width/left.
- C_IMG_HBITS, 12: width of row coordinates and window height/top.
- C_STEP_BITS, 4: width of the stride inputs.

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- win_left  in  C_IMG_WBITS  first window column.
- win_top  in  C_IMG_HBITS  first window row.
- win_width  in  C_IMG_WBITS  window width in input pixels; 0 = empty.
- win_height  in  C_IMG_HBITS  window height in input rows; 0 = empty.
- win_hstep  in  C_STEP_BITS  horizontal stride; 0 treated as 1.
- win_vstep  in  C_STEP_BITS  vertical stride; 0 treated as 1.
- s_axis_tdata  in  C_PIXEL_WIDTH  input pixel.
- s_axis_tuser  in  1  start of frame (first pixel).
- s_axis_tlast  in  1  end of line.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  C_PIXEL_WIDTH  output pixel.
- m_axis_tuser  out  1  first output pixel of frame.
- m_axis_tlast  out  1  last output pixel of each output row.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

Behaviour:
- Reset: m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0. State=WAIT_SOF; col/row/step counters=0; shadow window regs=0. s_axis_tready=1 after reset.
- Ready rule: s_axis_tready = ~m_axis_tvalid | m_axis_tready.
- Output register: single stage, no combinational path from s_* to m_*. Latency is 1 cycle from input accept to m_axis_tvalid.
- Accept = s_axis_tvalid & s_axis_tready. Unselected beats are consumed and dropped.
- m_axis_t* are held stable while m_axis_tvalid & ~m_axis_tready.
- FSM WAIT_SOF: accepted beats without tuser are dropped. An accepted beat with tuser goes to ACTIVE and is processed as pixel (0,0).
- FSM ACTIVE: stays in ACTIVE; every accepted tuser restarts the frame.
- On any accepted tuser beat:
  - latch all win_* into shadow regs; that beat already uses the new values;
  - col=0, row=0;
  - frame_first flag=1.
- Window inputs changing mid-frame have no effect until the next accepted SOF.
- Counters:
  - accepted beat with tlast: col=0, row+1;
  - otherwise col+1;
  - row and col saturate at all-ones.
- Selection: sel = in_h & in_v & hphase==0 & vphase==0.
  - in_h = col >= left and col < left+width.
  - in_v = row >= top and row < top+height.
  - Compare sums one bit wider than the operands; no wrap.
- Phases: hphase counts 0..hstep-1 starting at col==left and is reset on each line. vphase counts 0..vstep-1 starting at row==top. Implement with counters, not modulo.
- m_axis_tuser=1 on the first selected beat after SOF (frame_first), which then clears frame_first.
- m_axis_tlast = sel & (s_axis_tlast | col+hstep >= left+width). This truncates a window that extends past the input line at the real EOL.
- Empty window (width==0 or height==0 latched): no beats are output for that frame; input keeps draining at full rate.
- Window entirely outside the frame: no output; no spurious tuser/tlast.
- Short frame (tuser arrives early): the current output row is not closed; the new frame starts cleanly.
- Simultaneous tuser and tlast on one beat: treated as a 1-pixel line; row becomes 1 after it.
- resetn low mid-frame: all state returns to reset values next edge. The pending output beat is discarded. The block waits for a new SOF.

Decomposition:
- Shared package axis_video_pkg holds the FSM state encoding (WAIT_SOF, ACTIVE) and the stride-normalisation function (0 to 1).
- One sub-module, axis_window_v2_coord: counters, phases, shadow registers and the sel/tuser/tlast flags, combinational on the accept beat.
- The top level holds the FSM, handshake and output register.

Test Plan:
- Basic crop. Stimulus: 16x8 frame, tdata=row*16+col, left=3 top=2 w=5 h=3 step=1/1, m_ready=1. Required: 15 beats 0x23..0x27, 0x33..0x37, 0x43..0x47; tuser only on 0x23; tlast on 0x27, 0x37, 0x47.
- Decimation. Stimulus: same frame, left=3 top=2 w=5 h=4 hstep=2 vstep=2. Required: 0x23, 0x25, 0x27, 0x43, 0x45, 0x47; tlast on 0x27 and 0x47.
- Edge truncation. Stimulus: left=14 w=5 top=6 h=5. Required: 0x6E, 0x6F(tlast), 0x7E, 0x7F(tlast); no beats after row 7.
- Empty window and per-frame latching. Stimulus: w=0 on frame 1, switch to w=5 h=6 left=3 top=3 mid-frame 1. Required: frame 1 gives zero output beats; frame 2 gives 30 beats starting 0x33 with tuser.
- Random backpressure. Stimulus: basic crop with random s_valid/m_ready (50%), 3 back-to-back frames. Required: identical beat sequence per frame; data stable while stalled; no lost or duplicated beats.
- Reset and no-SOF start. Stimulus: resetn low at row 4 mid-frame, then stream starts mid-frame. Required: m_valid=0 next cycle; output resumes only after the next tuser beat.
